// File: rtl/seq_ctrl_pkg.sv
// Shared types and reset-time constants for the serial pattern detector.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [7:0] RST_PAT = 8'b0000_1101;
    localparam logic [3:0] RST_LEN = 4'd4;
    localparam logic       RST_OVL = 1'b1;
    localparam logic [7:0] RST_TGT = 8'd0;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, valid-bit counter and pattern comparator.
module seq_match_core #(
    parameter int unsigned PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in,
    input  logic [PAT_W-1:0] pat,
    input  logic [3:0]       len,
    input  logic             overlap,
    output logic             match_c
);

    localparam int unsigned BCW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d, shifted, mask;
    logic [BCW-1:0]   bcnt_q, bcnt_d, bcnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            bcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        hist_d   = hist_q;
        bcnt_d   = bcnt_q;
        match_c  = 1'b0;
        shifted  = {hist_q[PAT_W-2:0], in};
        mask     = (PAT_W'(1) << len) - PAT_W'(1);
        bcnt_inc = (32'(bcnt_q) >= PAT_W) ? bcnt_q : bcnt_q + BCW'(1);
        if (clear) begin
            hist_d = '0;
            bcnt_d = '0;
        end else if (shift_en) begin
            hist_d = shifted;
            bcnt_d = bcnt_inc;
            if ((32'(bcnt_inc) >= 32'(len)) && (((shifted ^ pat) & mask) == '0)) begin
                match_c = 1'b1;
                // without overlap, the next match must be built from fresh bits only
                if (!overlap) begin
                    bcnt_d = '0;
                end
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-control FSM, match counter and config registers around the match core.
module seq_det_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_d, cnt_inc;
    logic             out_d, err_d, busy_d, done_d;
    logic             clear_c, shift_en_c, match_c, cfg_ok_c;

    assign clear_c    = (state_q != S_RUN) && start;
    assign shift_en_c = (state_q == S_RUN) && !stop && in_valid;
    assign cfg_ok_c   = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_W);
    assign cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_c),
        .shift_en (shift_en_c),
        .in       (in),
        .pat      (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match_c  (match_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= PAT_W'(RST_PAT);
            len_q     <= RST_LEN;
            ovl_q     <= RST_OVL;
            tgt_q     <= CNT_W'(RST_TGT);
            match_cnt <= '0;
            out       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            match_cnt <= cnt_d;
            out       <= out_d;
            busy      <= busy_d;
            done      <= done_d;
            cfg_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        cnt_d   = match_cnt;
        out_d   = 1'b0;
        err_d   = 1'b0;

        // config only accepted outside a run and with a usable length
        if (cfg_we) begin
            if ((state_q != S_RUN) && cfg_ok_c) begin
                pat_d = cfg_pat;
                len_d = cfg_len;
                ovl_d = cfg_overlap;
                tgt_d = cfg_target;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (match_c) begin
                    out_d = 1'b1;
                    cnt_d = cnt_inc;
                    if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed and randomized checks of seq_det_ctrl against a bit-queue reference model.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, start, stop, din, in_valid;
    logic [7:0] cfg_pat, cfg_target;
    logic [3:0] cfg_len;
    logic       out, busy, done, cfg_err;
    logic [7:0] match_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_st;          // 0 idle, 1 run, 2 done
    int         m_cnt;
    logic       m_out, m_err;
    logic [7:0] m_pat;
    int         m_len, m_tgt;
    logic       m_ovl;
    logic       bits[$];

    seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .in          (din),
        .in_valid    (in_valid),
        .out         (out),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic tail_matches();
        int sz = bits.size();
        if (sz < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (bits[sz - m_len + i] !== m_pat[m_len - 1 - i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_st = 0; m_cnt = 0; m_out = 0; m_err = 0;
            m_pat = 8'b0000_1101; m_len = 4; m_ovl = 1; m_tgt = 0;
            bits.delete();
            return;
        end
        m_out = 0;
        m_err = 0;
        if (cfg_we) begin
            if (m_st != 1 && cfg_len >= 1 && cfg_len <= 8) begin
                m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
            end else begin
                m_err = 1;
            end
        end
        if (m_st != 1) begin
            if (start) begin
                m_st = 1; m_cnt = 0; bits.delete();
            end
        end else if (stop) begin
            m_st = 0;
        end else if (in_valid) begin
            bits.push_back(din);
            if (bits.size() > 8) void'(bits.pop_front());
            if (tail_matches()) begin
                m_out = 1;
                if (m_cnt < 255) m_cnt++;
                if (!m_ovl) bits.delete();
                if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
            end
        end
    endtask

    // one clock: update model with the sampled inputs, then compare every output
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_st == 1));
        chk("done", 32'(done), 32'(m_st == 2));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic send(input logic b);
        din = b; in_valid = 1'b1; cyc(); in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i] == "1");
    endtask

    task automatic do_start(); start = 1'b1; cyc(); start = 1'b0; endtask
    task automatic do_stop();  stop  = 1'b1; cyc(); stop  = 1'b0; endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        cfg_pat = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_overlap = 1'b0; start = 1'b0; stop = 1'b0;
        din = 1'b0; in_valid = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_target = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_busy", 32'(busy), 0);

        // reset config detects 1101
        do_start();
        chk("start_busy", 32'(busy), 1);
        send_str("110");
        chk("no_early_out", 32'(out), 0);
        send(1'b1);
        chk("r37_out", 32'(out), 1);
        chk("r37_cnt", 32'(match_cnt), 1);
        din = 1'b0; cyc();
        chk("r37_pulse_len", 32'(out), 0);

        do_stop(); do_start();
        send_str("100011101");
        chk("r38_cnt", 32'(match_cnt), 1);

        do_stop(); do_start();
        send_str("1101101");
        chk("r39_ovl_cnt", 32'(match_cnt), 2);
        do_stop();
        chk("stop_holds_cnt", 32'(match_cnt), 2);
        do_cfg(8'b0000_1101, 4'd4, 1'b0, 8'd0);
        do_start();
        send_str("1101101");
        chk("r39_noovl_cnt", 32'(match_cnt), 1);

        do_stop();
        do_cfg(8'b0000_1101, 4'd4, 1'b1, 8'd2);
        do_start();
        send_str("1101101");
        chk("r40_done", 32'(done), 1);
        chk("r40_busy", 32'(busy), 0);
        send_str("1101");
        chk("r40_ignored", 32'(match_cnt), 2);

        do_cfg(8'hFF, 4'd0, 1'b0, 8'd0);
        chk("r41_len0_err", 32'(cfg_err), 1);
        do_cfg(8'hFF, 4'd9, 1'b0, 8'd0);
        chk("r41_len9_err", 32'(cfg_err), 1);
        do_start();
        do_cfg(8'hFF, 4'd3, 1'b0, 8'd0);
        chk("r41_run_err", 32'(cfg_err), 1);
        send_str("1101");
        chk("r41_still_1101", 32'(match_cnt), 1);

        // config and start on the same edge: the run uses the new pattern
        do_stop();
        cfg_pat = 8'b0000_0101; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_target = 8'd0;
        cfg_we = 1'b1; start = 1'b1; cyc(); cfg_we = 1'b0; start = 1'b0;
        send_str("101");
        chk("r31_newcfg", 32'(match_cnt), 1);

        // reset on the edge that would complete a match
        do_stop(); do_cfg(8'b0000_1101, 4'd4, 1'b1, 8'd0); do_start();
        send_str("110");
        din = 1'b1; in_valid = 1'b1; rst = 1'b1; cyc(); rst = 1'b0; in_valid = 1'b0;
        chk("r34_no_out", 32'(out), 0);
        do_start();
        send(1'b1);
        chk("r42_no_match", 32'(match_cnt), 0);
        do_start();
        send_str("1101");
        chk("r42_match", 32'(match_cnt), 1);

        // counter saturation with a one-bit pattern
        do_stop(); do_cfg(8'h01, 4'd1, 1'b1, 8'd0); do_start();
        for (int i = 0; i < 300; i++) send(1'b1);
        chk("sat_cnt", 32'(match_cnt), 255);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            do_stop();
            do_cfg(8'($urandom), 4'($urandom_range(1, 8)), 1'($urandom), 8'($urandom_range(0, 4)));
            do_start();
            for (int k = 0; k < 200; k++) begin
                din        = 1'($urandom);
                in_valid   = ($urandom_range(0, 3) != 0);
                stop       = ($urandom_range(0, 60) == 0);
                start      = ($urandom_range(0, 30) == 0);
                cfg_we     = ($urandom_range(0, 40) == 0);
                cfg_pat    = 8'($urandom);
                cfg_len    = 4'($urandom_range(0, 10));
                cfg_overlap = 1'($urandom);
                cfg_target = 8'($urandom_range(0, 4));
                cyc();
            end
            stop = 1'b0; start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
